// File: rtl/div_pkg.sv
// div_pkg: shared state type and constants for the sequential divider.
// The DIV_FASTPATH_EN option itself lives in seq_divider16by8.
package div_pkg;

    localparam int DIV_DW = 8;
    localparam int DIV_ITER = DIV_DW;

    localparam logic [DIV_DW-1:0] QUOT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Kept standalone so an unrolled variant can chain copies of it.
module div_step
    import div_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic [DW-1:0] r,
    input  logic          q_msb,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] r_next,
    output logic          q_bit
);

    logic [DW:0]   sh;
    logic [DW-1:0] t;

    assign sh = {r, q_msb};

    // When the subtract succeeds the result is below d, so DW bits hold it.
    assign t      = sh[DW-1:0] - d;
    assign q_bit  = (sh >= {1'b0, d});
    assign r_next = q_bit ? t : sh[DW-1:0];

endmodule

// File: rtl/seq_divider16by8.sv
// seq_divider16by8: iterative restoring 2*DW / DW divider, one bit per cycle.
// Define DIV_FASTPATH_EN to finish divide-by-one and zero dividends at accept.
module seq_divider16by8
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          ovf,
    output logic          busy
);

    localparam logic [DW-1:0] SAT =
        (DW == DIV_DW) ? QUOT_SAT : '1;

    div_state_t state_q, state_n;

    logic [DW-1:0] d_q, d_n;
    logic [DW-1:0] r_q, r_n;
    logic [DW-1:0] q_q, q_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [DW-1:0] quot_q, quot_n;
    logic [DW-1:0] rem_q, rem_n;
    logic          ovf_q, ovf_n;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;

    logic [DW-1:0] div_hi, div_lo;
    logic [DW-1:0] r_step;
    logic          q_bit;
    logic          accept;
    logic          ovf_chk;

    assign div_hi  = dividend[2*DW-1:DW];
    assign div_lo  = dividend[DW-1:0];
    assign accept  = in_valid && in_ready_q;
    assign ovf_chk = (divisor == '0) || (div_hi >= divisor);

    div_step #(
        .DW(DW)
    ) u_step (
        .r      (r_q),
        .q_msb  (q_q[DW-1]),
        .d      (d_q),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

    always_comb begin
        state_n = state_q;
        d_n     = d_q;
        r_n     = r_q;
        q_n     = q_q;
        cnt_n   = cnt_q;
        quot_n  = quot_q;
        rem_n   = rem_q;
        ovf_n   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    d_n = divisor;
                    if (ovf_chk) begin
                        quot_n  = SAT;
                        rem_n   = div_lo;
                        ovf_n   = 1'b1;
                        state_n = DONE;
                    end
`ifdef DIV_FASTPATH_EN
                    else if (divisor == DW'(1) ||
                             dividend == '0) begin
                        quot_n  = (divisor == DW'(1)) ?
                                  div_lo : '0;
                        rem_n   = '0;
                        ovf_n   = 1'b0;
                        state_n = DONE;
                    end
`endif
                    else begin
                        r_n     = div_hi;
                        q_n     = div_lo;
                        cnt_n   = CW'(DW - 1);
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                r_n = r_step;
                q_n = {q_q[DW-2:0], q_bit};
                if (cnt_q == '0) begin
                    quot_n  = {q_q[DW-2:0], q_bit};
                    rem_n   = r_step;
                    ovf_n   = 1'b0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            d_q         <= d_n;
            r_q         <= r_n;
            q_q         <= q_n;
            cnt_q       <= cnt_n;
            quot_q      <= quot_n;
            rem_q       <= rem_n;
            ovf_q       <= ovf_n;
            in_ready_q  <= (state_n == IDLE);
            out_valid_q <= (state_n == DONE);
            busy_q      <= (state_n != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_divider16by8.sv
// tb_seq_divider16by8: scoreboard bench for the sequential divider.
// Driver queues expected results; a negedge monitor checks every output.
module tb_seq_divider16by8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        busy;

    seq_divider16by8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [7:0]  d;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        o;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   bp_hold = 0;
    bit   held = 0;
    bit   gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    // Cycles from the accept edge until out_valid is seen.
    function automatic int lat_of(input logic [15:0] x,
                                  input logic [7:0] d);
        if (d == 0 || x[15:8] >= d) return 1;
`ifdef DIV_FASTPATH_EN
        if (d == 1 || x == 0) return 1;
`endif
        return 9;
    endfunction

    task automatic issue(input logic [15:0] x,
                         input logic [7:0]  d,
                         input logic [7:0]  eq,
                         input logic [7:0]  er,
                         input logic        eo);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            fail_now("in_ready_wait");
            return;
        end
        in_valid = 1'b1;
        dividend = x;
        divisor  = d;
        sb.push_back('{x, d, eq, er, eo, lat_of(x, d), cyc});
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic issue_model(input logic [15:0] x,
                               input logic [7:0]  d);
        if (d == 0 || x[15:8] >= d)
            issue(x, d, 8'hFF, x[7:0], 1'b1);
        else
            issue(x, d, 8'(x / d), 8'(x % d), 1'b0);
    endtask

    task automatic wait_empty(input string nm);
        int w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            fail_now(nm);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held      = 0;
            gap       = 0;
            out_ready = 1'b0;
        end else begin
            if (gap) begin
                chk("valid_drop", 32'(out_valid), 0);
                gap = 0;
            end
            if (out_valid && sb.size() == 0) begin
                fail_now("unexpected_output");
                out_ready = 1'b1;
            end else if (out_valid) begin
                if (!held) begin
                    chk("latency", cyc - sb[0].acc, sb[0].lat);
                    held = 1;
                end
                chk("quotient", 32'(quotient), 32'(sb[0].q));
                chk("remainder", 32'(remainder), 32'(sb[0].r));
                chk("ovf", 32'(ovf), 32'(sb[0].o));
                chk("in_ready_done", 32'(in_ready), 0);
                chk("busy_done", 32'(busy), 1);
                if (!sb[0].o) begin
                    chk("invariant",
                        32'(quotient) * 32'(sb[0].d)
                        + 32'(remainder), 32'(sb[0].x));
                    chk("rem_lt_div",
                        32'(remainder < sb[0].d), 1);
                end
                if (bp_hold > 0) begin
                    out_ready = 1'b0;
                    bp_hold--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    held = 0;
                    gap  = 1;
                end
            end else begin
                out_ready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin
        logic [15:0] x;
        logic [7:0]  d;
        int          sel;
        int          w;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_quotient", 32'(quotient), 0);
        chk("rst_remainder", 32'(remainder), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0);
        issue(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0);
        issue(16'h8000, 8'h40, 8'hFF, 8'h00, 1'b1);
        issue(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1);
        wait_empty("drain_directed");

        // Hold the consumer off and poke in_valid while DONE.
        bp_hold = 5;
        issue(16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        repeat (3) begin
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        issue(16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0);
        wait_empty("drain_bp");

        // Abort an operation in its fourth CALC cycle.
        issue(16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 chk("abort_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        chk("rel_out_valid", 32'(out_valid), 0);
        chk("rel_busy", 32'(busy), 0);
        chk("rel_quotient", 32'(quotient), 0);
        chk("rel_remainder", 32'(remainder), 0);
        chk("rel_ovf", 32'(ovf), 0);
        @(negedge clk);
        issue(16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0);
        issue(16'h00C8, 8'h01, 8'hC8, 8'h00, 1'b0);
        issue(16'h0000, 8'h37, 8'h00, 8'h00, 1'b0);
        wait_empty("drain_post_reset");

        for (int i = 0; i < 3000; i++) begin
            d   = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 15);
            if (sel == 0) d = 8'h01;
            if (sel == 1) d = 8'h00;
            x = 16'($urandom);
            if (sel < 12 && d != 0)
                x[15:8] = 8'($urandom_range(0, int'(d) - 1));
            if (sel == 2) x = 16'h0000;
            issue_model(x, d);
        end
        wait_empty("drain_random");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
